// File: rtl/aexm_lsu_ctl_if.sv
// ----------------------------------------------------------------------------
// aexm_lsu_ctl_if
//  Bundles the execute-stage request, the dcache handshake and the
//  load-sizer and exception outputs of aexm_lsu_ctl.
//  modport slave  : the sequencer (requests and dc_ack in, everything else out)
//  modport master : the surrounding pipeline/cache model (mirror image)
//  Signals:
//   ls_req, ls_we, ls_size[1:0], ls_addr[31:0]  execute-stage request
//   dc_ack                                      dcache completion
//   x_en                                        pipeline enable
//   dc_req, dc_we, dc_addr[29:0], dc_sel[3:0]   dcache request
//   rDWBSEL[3:0]                                load-sizer lane select (WB)
//   ls_berr, ls_align                           time-out / misalign pulses
// ----------------------------------------------------------------------------
interface aexm_lsu_ctl_if;
    logic        ls_req;
    logic        ls_we;
    logic [1:0]  ls_size;
    logic [31:0] ls_addr;
    logic        dc_ack;
    logic        x_en;
    logic        dc_req;
    logic        dc_we;
    logic [29:0] dc_addr;
    logic [3:0]  dc_sel;
    logic [3:0]  rDWBSEL;
    logic        ls_berr;
    logic        ls_align;

    modport slave (
        input  ls_req, ls_we, ls_size, ls_addr, dc_ack,
        output x_en, dc_req, dc_we, dc_addr, dc_sel, rDWBSEL, ls_berr, ls_align
    );

    modport master (
        output ls_req, ls_we, ls_size, ls_addr, dc_ack,
        input  x_en, dc_req, dc_we, dc_addr, dc_sel, rDWBSEL, ls_berr, ls_align
    );
endinterface

// File: rtl/aexm_lsu_ctl.sv
// ----------------------------------------------------------------------------
// aexm_lsu_ctl
//  Load/store sequencer between the aexm execute stage and the dcache port.
//  Accepts one access per request, runs the dc_req/dc_ack handshake, builds
//  big-endian byte lanes and the WB lane select, stalls the pipeline through
//  x_en while an access is outstanding, and abandons an access on time-out.
//  Ports:
//   gclk  clock, rising edge
//   grst  synchronous active-low reset
//   lsu   aexm_lsu_ctl_if.slave (request, dcache handshake, status pulses)
//  Parameters:
//   TMO_MAX  REQ cycles without dc_ack before ls_berr; 0 disables the time-out
//   TMO_W    time-out counter width, 2**TMO_W > TMO_MAX
//  Build option:
//   AEXM_ALIGN_TRAP_EN  defined: misaligned requests are trapped (ls_align
//                       pulse, no dcache request); undefined: misaligned low
//                       address bits are ignored and ls_align stays 0.
// ----------------------------------------------------------------------------
module aexm_lsu_ctl #(
    parameter int unsigned TMO_MAX = 255,
    parameter int unsigned TMO_W   = 8
) (
    input  logic          gclk,
    input  logic          grst,
    aexm_lsu_ctl_if.slave lsu
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WB   = 2'd2
    } state_e;

    localparam bit               TMO_EN   = (TMO_MAX != 0);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_MAX - 1);

    state_e             state_q,    state_d;
    logic               x_en_q,     x_en_d;
    logic               dc_req_q,   dc_req_d;
    logic               dc_we_q,    dc_we_d;
    logic [29:0]        dc_addr_q,  dc_addr_d;
    logic [3:0]         dc_sel_q,   dc_sel_d;
    logic [3:0]         rdwbsel_q,  rdwbsel_d;
    logic               ls_berr_q,  ls_berr_d;
    logic               ls_align_q, ls_align_d;
    logic [TMO_W-1:0]   cnt_q,      cnt_d;

    logic [3:0]         sel_c;
    logic               trap_c;

    // Byte lanes from size and address; half/word ignore the low bits that
    // would make them misaligned, which is the forced-alignment behaviour.
    always_comb begin
        sel_c = 4'hF;
        case (lsu.ls_size)
            2'd0:    sel_c = 4'b1000 >> lsu.ls_addr[1:0];
            2'd1:    sel_c = lsu.ls_addr[1] ? 4'b0011 : 4'b1100;
            default: sel_c = 4'hF;
        endcase
    end

    // Misaligned-request trap condition.
    always_comb begin
`ifdef AEXM_ALIGN_TRAP_EN
        trap_c = ((lsu.ls_size == 2'd1) && lsu.ls_addr[0]) ||
                 (lsu.ls_size[1] && (lsu.ls_addr[1:0] != 2'b00));
`else
        trap_c = 1'b0;
`endif
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        x_en_d     = x_en_q;
        dc_req_d   = dc_req_q;
        dc_we_d    = dc_we_q;
        dc_addr_d  = dc_addr_q;
        dc_sel_d   = dc_sel_q;
        cnt_d      = cnt_q;
        rdwbsel_d  = 4'h0;
        ls_berr_d  = 1'b0;
        ls_align_d = 1'b0;

        case (state_q)
            ST_IDLE, ST_WB: begin
                if (lsu.ls_req && x_en_q && trap_c) begin
                    state_d    = ST_IDLE;
                    x_en_d     = 1'b1;
                    dc_req_d   = 1'b0;
                    ls_align_d = 1'b1;
                end else if (lsu.ls_req && x_en_q) begin
                    state_d   = ST_REQ;
                    x_en_d    = 1'b0;
                    dc_req_d  = 1'b1;
                    cnt_d     = '0;
                    dc_we_d   = lsu.ls_we;
                    dc_addr_d = lsu.ls_addr[31:2];
                    dc_sel_d  = sel_c;
                end else begin
                    state_d  = ST_IDLE;
                    x_en_d   = 1'b1;
                    dc_req_d = 1'b0;
                end
            end
            ST_REQ: begin
                // Ack has priority over a time-out on the same cycle.
                if (lsu.dc_ack) begin
                    state_d   = ST_WB;
                    x_en_d    = 1'b1;
                    dc_req_d  = 1'b0;
                    rdwbsel_d = dc_we_q ? 4'h0 : dc_sel_q;
                end else if (TMO_EN && (cnt_q == TMO_LAST)) begin
                    state_d   = ST_IDLE;
                    x_en_d    = 1'b1;
                    dc_req_d  = 1'b0;
                    ls_berr_d = 1'b1;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + TMO_W'(1);
                end
            end
            default: begin
                state_d  = ST_IDLE;
                x_en_d   = 1'b1;
                dc_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge gclk) begin
        if (!grst) begin
            state_q    <= ST_IDLE;
            x_en_q     <= 1'b1;
            dc_req_q   <= 1'b0;
            dc_we_q    <= 1'b0;
            dc_addr_q  <= '0;
            dc_sel_q   <= 4'h0;
            rdwbsel_q  <= 4'h0;
            ls_berr_q  <= 1'b0;
            ls_align_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            x_en_q     <= x_en_d;
            dc_req_q   <= dc_req_d;
            dc_we_q    <= dc_we_d;
            dc_addr_q  <= dc_addr_d;
            dc_sel_q   <= dc_sel_d;
            rdwbsel_q  <= rdwbsel_d;
            ls_berr_q  <= ls_berr_d;
            ls_align_q <= ls_align_d;
            cnt_q      <= cnt_d;
        end
    end

    assign lsu.x_en     = x_en_q;
    assign lsu.dc_req   = dc_req_q;
    assign lsu.dc_we    = dc_we_q;
    assign lsu.dc_addr  = dc_addr_q;
    assign lsu.dc_sel   = dc_sel_q;
    assign lsu.rDWBSEL  = rdwbsel_q;
    assign lsu.ls_berr  = ls_berr_q;
    assign lsu.ls_align = ls_align_q;

endmodule

// File: tb/tb_aexm_lsu_ctl.sv
// ----------------------------------------------------------------------------
// tb_aexm_lsu_ctl
//  Bench for aexm_lsu_ctl. u_dut uses the default time-out; u_tmo uses
//  TMO_MAX=4 for the time-out cases. Expected dcache requests are queued
//  when an access is driven and compared when dc_req rises.
// ----------------------------------------------------------------------------
module tb_aexm_lsu_ctl;

    logic gclk = 1'b0;
    logic grst;

    always #5 gclk = ~gclk;

    aexm_lsu_ctl_if mif ();
    aexm_lsu_ctl_if tif ();

    aexm_lsu_ctl u_dut (
        .gclk (gclk),
        .grst (grst),
        .lsu  (mif)
    );

    aexm_lsu_ctl #(
        .TMO_MAX (4),
        .TMO_W   (3)
    ) u_tmo (
        .gclk (gclk),
        .grst (grst),
        .lsu  (tif)
    );

    typedef struct packed {
        logic [29:0] addr;
        logic [3:0]  sel;
        logic        we;
    } exp_t;

    exp_t sb_q[$];
    int   n_total = 0;
    int   n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    // Reference lane table, big-endian ([3] = byte address 0).
    function automatic logic [3:0] exp_sel(input logic [1:0] size, input logic [31:0] addr);
        logic [3:0] key;
        key = {size, addr[1:0]};
        case (key)
            4'b0000: return 4'h8;
            4'b0001: return 4'h4;
            4'b0010: return 4'h2;
            4'b0011: return 4'h1;
            4'b0100, 4'b0101: return 4'hC;
            4'b0110, 4'b0111: return 4'h3;
            default: return 4'hF;
        endcase
    endfunction

    // Request monitor: payload on the rising dc_req, then held stable.
    logic req_prev = 1'b0;
    exp_t cur = '0;
    always @(negedge gclk) begin
        if (grst === 1'b1 && mif.dc_req === 1'b1) begin
            if (!req_prev) begin
                if (sb_q.size() == 0) begin
                    chk("sb_empty", 32'(sb_q.size()), 32'd1);
                end else begin
                    cur = sb_q.pop_front();
                    chk("dc_addr", 32'(mif.dc_addr), 32'(cur.addr));
                    chk("dc_sel",  32'(mif.dc_sel),  32'(cur.sel));
                    chk("dc_we",   32'(mif.dc_we),   32'(cur.we));
                end
            end else begin
                chk("hold_addr", 32'(mif.dc_addr), 32'(cur.addr));
                chk("hold_sel",  32'(mif.dc_sel),  32'(cur.sel));
                chk("hold_we",   32'(mif.dc_we),   32'(cur.we));
            end
        end
        req_prev = (mif.dc_req === 1'b1);
    end

    task automatic step();
        @(posedge gclk);
        #1;
    endtask

    // One access on u_dut: request, 'delay' REQ cycles without ack, then ack.
    // poke drives a one-cycle ls_req in the middle of the stall.
    task automatic do_access(input logic [31:0] addr, input logic [1:0] size,
                             input logic we, input int delay, input bit poke);
        exp_t e;
        e.addr = addr[31:2];
        e.sel  = exp_sel(size, addr);
        e.we   = we;
        sb_q.push_back(e);
        mif.ls_req  = 1'b1;
        mif.ls_we   = we;
        mif.ls_size = size;
        mif.ls_addr = addr;
        step();
        mif.ls_req  = 1'b0;
        mif.ls_addr = $urandom;
        mif.ls_we   = ~we;
        chk("x_en_req",  32'(mif.x_en),   32'd0);
        chk("dc_req_on", 32'(mif.dc_req), 32'd1);
        for (int i = 0; i < delay; i++) begin
            if (poke && i == delay / 2) mif.ls_req = 1'b1;
            step();
            mif.ls_req = 1'b0;
            chk("x_en_stall", 32'(mif.x_en), 32'd0);
        end
        mif.dc_ack = 1'b1;
        step();
        mif.dc_ack = 1'b0;
        chk("x_en_wb",   32'(mif.x_en),    32'd1);
        chk("dc_req_wb", 32'(mif.dc_req),  32'd0);
        chk("rdwbsel",   32'(mif.rDWBSEL), 32'(we ? 4'h0 : e.sel));
    endtask

    task automatic idle_chk();
        step();
        chk("idle_rdwbsel", 32'(mif.rDWBSEL),  32'd0);
        chk("idle_x_en",    32'(mif.x_en),     32'd1);
        chk("idle_dc_req",  32'(mif.dc_req),   32'd0);
        chk("idle_align",   32'(mif.ls_align), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired @%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [1:0]  sz;
        grst = 1'b0;
        mif.ls_req = 1'b0; mif.ls_we = 1'b0; mif.ls_size = 2'd0; mif.ls_addr = '0; mif.dc_ack = 1'b0;
        tif.ls_req = 1'b0; tif.ls_we = 1'b0; tif.ls_size = 2'd0; tif.ls_addr = '0; tif.dc_ack = 1'b0;
        step();
        step();
        chk("rst_x_en",    32'(mif.x_en),     32'd1);
        chk("rst_dc_req",  32'(mif.dc_req),   32'd0);
        chk("rst_dc_we",   32'(mif.dc_we),    32'd0);
        chk("rst_dc_addr", 32'(mif.dc_addr),  32'd0);
        chk("rst_dc_sel",  32'(mif.dc_sel),   32'd0);
        chk("rst_rdwbsel", 32'(mif.rDWBSEL),  32'd0);
        chk("rst_berr",    32'(mif.ls_berr),  32'd0);
        chk("rst_align",   32'(mif.ls_align), 32'd0);
        chk("rst_t_x_en",  32'(tif.x_en),     32'd1);
        chk("rst_t_req",   32'(tif.dc_req),   32'd0);
        grst = 1'b1;
        step();

        // Byte load, ack on first REQ cycle.
        do_access(32'h0000_1003, 2'd0, 1'b0, 0, 1'b0);
        idle_chk();

        // Half store then word load requested in WB.
        do_access(32'h0000_2002, 2'd1, 1'b1, 0, 1'b0);
        do_access(32'h0000_3000, 2'd2, 1'b0, 0, 1'b0);
        idle_chk();

        // Misaligned word load.
`ifdef AEXM_ALIGN_TRAP_EN
        mif.ls_req = 1'b1; mif.ls_we = 1'b0; mif.ls_size = 2'd2; mif.ls_addr = 32'h0000_1001;
        step();
        mif.ls_req = 1'b0;
        chk("trap_align",  32'(mif.ls_align), 32'd1);
        chk("trap_dc_req", 32'(mif.dc_req),   32'd0);
        chk("trap_x_en",   32'(mif.x_en),     32'd1);
        step();
        chk("trap_pulse",  32'(mif.ls_align), 32'd0);
        chk("trap_req2",   32'(mif.dc_req),   32'd0);
`else
        do_access(32'h0000_1001, 2'd2, 1'b0, 0, 1'b0);
        idle_chk();
`endif

        // Mixed accesses, some chained, short ack delays.
        for (int n = 0; n < 10; n++) begin
            a  = $urandom;
            sz = 2'($urandom_range(0, 3));
`ifdef AEXM_ALIGN_TRAP_EN
            if (sz == 2'd1) a[0] = 1'b0;
            if (sz[1])      a[1:0] = 2'b00;
`endif
            do_access(a, sz, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b0);
            if ($urandom_range(0, 1) == 0) idle_chk();
        end
        idle_chk();

        // Long stall with an ls_req pulse that must be ignored.
        do_access(32'h0000_5550, 2'd2, 1'b1, 10, 1'b1);
        idle_chk();

        // dc_ack while idle is ignored.
        mif.dc_ack = 1'b1;
        step();
        mif.dc_ack = 1'b0;
        chk("ack_idle_req",  32'(mif.dc_req),  32'd0);
        chk("ack_idle_x_en", 32'(mif.x_en),    32'd1);
        chk("ack_idle_sel",  32'(mif.rDWBSEL), 32'd0);

        // Reset while a request is outstanding.
        begin
            exp_t e;
            e.addr = 30'h0000_2001; e.sel = 4'hF; e.we = 1'b0;
            sb_q.push_back(e);
        end
        mif.ls_req = 1'b1; mif.ls_we = 1'b0; mif.ls_size = 2'd2; mif.ls_addr = 32'h0000_8004;
        step();
        mif.ls_req = 1'b0;
        step();
        chk("pre_rst_req", 32'(mif.dc_req), 32'd1);
        grst = 1'b0;
        step();
        grst = 1'b1;
        chk("t1_dc_req",  32'(mif.dc_req),  32'd0);
        chk("t1_x_en",    32'(mif.x_en),    32'd1);
        chk("t1_rdwbsel", 32'(mif.rDWBSEL), 32'd0);
        chk("t1_dc_sel",  32'(mif.dc_sel),  32'd0);
        mif.dc_ack = 1'b1;
        step();
        mif.dc_ack = 1'b0;
        chk("t1_ack_req",  32'(mif.dc_req),  32'd0);
        chk("t1_ack_x_en", 32'(mif.x_en),    32'd1);
        chk("t1_ack_sel",  32'(mif.rDWBSEL), 32'd0);
        do_access(32'h0000_9006, 2'd1, 1'b0, 1, 1'b0);
        idle_chk();

        // Time-out with TMO_MAX=4: four REQ cycles then ls_berr.
        tif.ls_req = 1'b1; tif.ls_we = 1'b0; tif.ls_size = 2'd2; tif.ls_addr = 32'h0000_0040;
        step();
        tif.ls_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("tmo_req",  32'(tif.dc_req),  32'd1);
            chk("tmo_x_en", 32'(tif.x_en),    32'd0);
            chk("tmo_berr", 32'(tif.ls_berr), 32'd0);
            step();
        end
        chk("tmo_berr_hi", 32'(tif.ls_berr), 32'd1);
        chk("tmo_req_lo",  32'(tif.dc_req),  32'd0);
        chk("tmo_x_en_hi", 32'(tif.x_en),    32'd1);
        step();
        chk("tmo_berr_pulse", 32'(tif.ls_berr), 32'd0);

        // Ack on the fourth REQ cycle wins over the time-out.
        tif.ls_req = 1'b1;
        step();
        tif.ls_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("tmo2_req", 32'(tif.dc_req), 32'd1);
            step();
        end
        tif.dc_ack = 1'b1;
        step();
        tif.dc_ack = 1'b0;
        chk("tmo2_berr", 32'(tif.ls_berr), 32'd0);
        chk("tmo2_req",  32'(tif.dc_req),  32'd0);
        chk("tmo2_x_en", 32'(tif.x_en),    32'd1);
        chk("tmo2_sel",  32'(tif.rDWBSEL), 32'hF);
        step();
        chk("tmo2_berr2", 32'(tif.ls_berr), 32'd0);
        chk("tmo2_clr",   32'(tif.rDWBSEL), 32'd0);

        chk("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
